// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: sequences the DES key-schedule generator (load, generate, clear) and streams 16 round keys out.
// Latency: cache hit gives first rk_valid 3 cycles after start; a miss adds LOAD + GEN + CLR; at least 3 cycles per round key.
// Backpressure: rk_ready low holds ISSUE (rk_data/rk_idx frozen) indefinitely; start is ignored while ready=0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, is_enc, key_in         request (sampled only while ready=1)
//   ready                         idle and accepting a request
//   kg_load, kg_run, kg_is_enc,   generator control: key-load strobe, generate enable,
//   kg_key, kg_done               mode, post-PC-1 key, completion flag
//   kg_rd, kg_round, kg_rkey      generator round-key read port (kg_rkey valid the cycle after kg_rd)
//   rk_valid, rk_ready,           round-key stream to the round datapath
//   rk_idx, rk_data
//   done, err                     one-cycle completion / generator-timeout pulses
module des_key_sched_ctrl #(
    parameter int KEY_W      = 56,
    parameter int RK_W       = 48,
    parameter int ROUNDS     = 16,
    parameter int KG_TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_enc,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready,
    output logic             kg_load,
    output logic             kg_run,
    output logic             kg_is_enc,
    output logic [KEY_W-1:0] kg_key,
    input  logic             kg_done,
    output logic             kg_rd,
    output logic [4:0]       kg_round,
    input  logic [RK_W-1:0]  kg_rkey,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_idx,
    output logic [RK_W-1:0]  rk_data,
    output logic             done,
    output logic             err
);
    localparam int               CNT_W    = $clog2(KG_TIMEOUT + 1);
    // gen_cnt holds the number of completed GEN cycles, so the last allowed
    // GEN cycle is the one where it equals KG_TIMEOUT-1.
    localparam logic [CNT_W-1:0] GEN_LAST = CNT_W'(KG_TIMEOUT - 1);
    localparam logic [3:0]       RND_LAST = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GEN,
        S_CLR,
        S_FETCH,
        S_CAPT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] gen_cnt;
    logic [3:0]       rnd;
    logic             cache_valid;
    logic             gen_fail;
    logic             cache_hit;

    // kg_key/kg_is_enc only change on a miss, so they double as the cache tag.
    assign cache_hit = cache_valid && (key_in == kg_key) && (is_enc == kg_is_enc);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded outputs
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        kg_load   = 1'b0;
        kg_run    = 1'b0;
        kg_rd     = 1'b0;
        kg_round  = 5'd0;
        rk_valid  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = cache_hit ? S_FETCH : S_LOAD;
                end
            end
            S_LOAD: begin
                kg_load   = 1'b1;
                state_nxt = S_GEN;
            end
            S_GEN: begin
                kg_run = 1'b1;
                if (kg_done) begin
                    state_nxt = S_CLR;
                end else if (gen_cnt == GEN_LAST) begin
                    err       = 1'b1;
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                // kg_run low for one cycle lets the generator clear its own
                // round counter and done flag before we start reading.
                state_nxt = gen_fail ? S_IDLE : S_FETCH;
            end
            S_FETCH: begin
                kg_rd     = 1'b1;
                kg_round  = {1'b0, rnd} + 5'd1;
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    state_nxt = (rnd == RND_LAST) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: key/mode latch, cache flag, GEN counter, round counter, key capture
    always_ff @(posedge clk) begin
        if (rst) begin
            kg_key      <= '0;
            kg_is_enc   <= 1'b0;
            cache_valid <= 1'b0;
            gen_cnt     <= '0;
            gen_fail    <= 1'b0;
            rnd         <= 4'd0;
            rk_idx      <= 4'd0;
            rk_data     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rnd <= 4'd0;
                    if (start && !cache_hit) begin
                        kg_key      <= key_in;
                        kg_is_enc   <= is_enc;
                        cache_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    gen_cnt  <= '0;
                    gen_fail <= 1'b0;
                end
                S_GEN: begin
                    gen_cnt <= gen_cnt + 1'b1;
                    // GEN is left only on kg_done or on timeout, so the value
                    // written in the final GEN cycle tells CLR which way to go.
                    gen_fail <= !kg_done;
                    if (kg_done) begin
                        cache_valid <= 1'b1;
                    end
                end
                S_CAPT: begin
                    rk_data <= kg_rkey;
                    rk_idx  <= rnd;
                end
                S_ISSUE: begin
                    if (rk_ready) begin
                        rnd <= (rnd == RND_LAST) ? 4'd0 : rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    rnd <= 4'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
